// File: rtl/complex_result_accumulator.sv
// Complex MAC tail: sums ACC_LEN consecutive complex products from the multiplier
// and hands each sum downstream on a valid/ready channel.
module complex_result_accumulator #(
    parameter  int DATA_WIDTH = 8,
    parameter  int ACC_LEN    = 4,
    parameter  int GUARD_BITS = 4,
    localparam int IW         = 2*DATA_WIDTH,
    localparam int AW         = 2*DATA_WIDTH + GUARD_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sw_rst,
    input  logic                 in_val,
    output logic                 in_ready,
    input  logic signed [IW-1:0] in_re,
    input  logic signed [IW-1:0] in_im,
    output logic                 out_val,
    input  logic                 out_ready,
    output logic signed [AW-1:0] out_re,
    output logic signed [AW-1:0] out_im
);

    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

    typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic signed [AW-1:0]  r_acc_re;
    logic signed [AW-1:0]  r_acc_im;
    logic                  w_accept;
    logic                  w_last;
    logic signed [AW-1:0]  w_ext_re;
    logic signed [AW-1:0]  w_ext_im;

    function automatic logic signed [AW-1:0] sext(input logic signed [IW-1:0] x);
        return {{GUARD_BITS{x[IW-1]}}, x};
    endfunction

    // sw_rst wins over the handshake, so a product offered alongside it is never consumed
    assign w_accept = in_val && in_ready && !sw_rst;
    assign w_last   = (r_cnt == LAST);
    assign w_ext_re = sext(in_re);
    assign w_ext_im = sext(in_im);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (sw_rst) begin
            w_state_nxt = ST_ACC;
        end else begin
            case (r_state)
                ST_ACC: if (w_accept && w_last) w_state_nxt = ST_OUT;
                ST_OUT: if (out_ready)          w_state_nxt = ST_ACC;
                default:                        w_state_nxt = ST_ACC;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        out_val  = 1'b0;
        case (r_state)
            ST_ACC:  in_ready = 1'b1;
            ST_OUT:  out_val  = 1'b1;
            default: in_ready = 1'b1;
        endcase
    end

    // First beat of a group loads rather than adds, so the previous sum never leaks in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else if (sw_rst) begin
            r_cnt    <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (r_cnt == '0) begin
                r_acc_re <= w_ext_re;
                r_acc_im <= w_ext_im;
            end else begin
                r_acc_re <= r_acc_re + w_ext_re;
                r_acc_im <= r_acc_im + w_ext_im;
            end
        end
    end

    assign out_re = r_acc_re;
    assign out_im = r_acc_im;

endmodule

// File: tb/tb_complex_result_accumulator.sv
// Directed, table-driven bench for complex_result_accumulator at default parameters.
module tb_complex_result_accumulator;

    localparam int DW = 8;
    localparam int IW = 2*DW;
    localparam int AW = 2*DW + 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sw_rst;
    logic                 in_val;
    logic                 in_ready;
    logic signed [IW-1:0] in_re;
    logic signed [IW-1:0] in_im;
    logic                 out_val;
    logic                 out_ready;
    logic signed [AW-1:0] out_re;
    logic signed [AW-1:0] out_im;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic signed [IW-1:0] re [4];
        logic signed [IW-1:0] im [4];
        int                   hold;
        int                   exp_re;
        int                   exp_im;
    } vec_t;

    vec_t vecs [5];

    complex_result_accumulator #(
        .DATA_WIDTH(DW),
        .ACC_LEN   (4),
        .GUARD_BITS(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_rst   (sw_rst),
        .in_val   (in_val),
        .in_ready (in_ready),
        .in_re    (in_re),
        .in_im    (in_im),
        .out_val  (out_val),
        .out_ready(out_ready),
        .out_re   (out_re),
        .out_im   (out_im)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_val(input string nm, input logic signed [AW-1:0] act, input int exp);
        logic signed [AW-1:0] e;
        e = AW'(exp);
        n_checks++;
        if (act !== e) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, e, $time);
        end
    endtask

    // Feeds one 4-beat group, optionally stalls the output for v.hold cycles, then drains it
    task automatic run_vec(input vec_t v, input int idx);
        out_ready = (v.hold == 0);
        for (int b = 0; b < 4; b++) begin
            in_val = 1'b1;
            in_re  = v.re[b];
            in_im  = v.im[b];
            chk_bit($sformatf("v%0d_rdy_b%0d", idx, b), in_ready, 1'b1);
            chk_bit($sformatf("v%0d_oval_b%0d", idx, b), out_val, 1'b0);
            tick();
        end
        in_val = 1'b0;
        chk_bit($sformatf("v%0d_oval", idx), out_val, 1'b1);
        chk_bit($sformatf("v%0d_rdy_out", idx), in_ready, 1'b0);
        chk_val($sformatf("v%0d_re", idx), out_re, v.exp_re);
        chk_val($sformatf("v%0d_im", idx), out_im, v.exp_im);
        for (int h = 0; h < v.hold; h++) begin
            in_val = 1'b1;
            in_re  = 16'sd77;
            in_im  = -16'sd55;
            tick();
            chk_bit($sformatf("v%0d_hold_oval%0d", idx, h), out_val, 1'b1);
            chk_bit($sformatf("v%0d_hold_rdy%0d", idx, h), in_ready, 1'b0);
            chk_val($sformatf("v%0d_hold_re%0d", idx, h), out_re, v.exp_re);
            chk_val($sformatf("v%0d_hold_im%0d", idx, h), out_im, v.exp_im);
        end
        in_val    = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_bit($sformatf("v%0d_oval_drop", idx), out_val, 1'b0);
        chk_bit($sformatf("v%0d_rdy_back", idx), in_ready, 1'b1);
        chk_val($sformatf("v%0d_re_persist", idx), out_re, v.exp_re);
    endtask

    task automatic beat(input logic v, input int re, input int im);
        in_val = v;
        in_re  = IW'(re);
        in_im  = IW'(im);
        tick();
    endtask

    initial begin
        vecs[0].re = '{16'sd1, 16'sd3, 16'sd5, 16'sd7};
        vecs[0].im = '{16'sd2, -16'sd4, 16'sd6, 16'sd8};
        vecs[0].hold = 0; vecs[0].exp_re = 16; vecs[0].exp_im = 12;
        vecs[1].re = '{16'sd1, 16'sd3, 16'sd5, 16'sd7};
        vecs[1].im = '{16'sd2, -16'sd4, 16'sd6, 16'sd8};
        vecs[1].hold = 5; vecs[1].exp_re = 16; vecs[1].exp_im = 12;
        vecs[2].re = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        vecs[2].im = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        vecs[2].hold = 0; vecs[2].exp_re = 4; vecs[2].exp_im = 4;
        vecs[3].re = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        vecs[3].im = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[3].hold = 1; vecs[3].exp_re = -131072; vecs[3].exp_im = 131068;
        vecs[4].re = '{-16'sd1, -16'sd2, 16'sd100, 16'h8000};
        vecs[4].im = '{-16'sd1, 16'sd5, -16'sd100, 16'sd0};
        vecs[4].hold = 0; vecs[4].exp_re = -32671; vecs[4].exp_im = -96;

        rst = 1'b1; sw_rst = 1'b0; in_val = 1'b0; out_ready = 1'b0;
        in_re = '0; in_im = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_bit("rst_oval", out_val, 1'b0);
        chk_val("rst_re", out_re, 0);
        chk_val("rst_im", out_im, 0);
        rst = 1'b0;
        #1;
        chk_bit("rst_rdy", in_ready, 1'b1);
        tick();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // sw_rst mid-group: the (9,9) beat offered alongside it must be dropped
        beat(1'b1, 100, 100);
        beat(1'b1, 100, 100);
        sw_rst = 1'b1;
        beat(1'b1, 9, 9);
        sw_rst = 1'b0;
        in_val = 1'b0;
        chk_val("swrst_re", out_re, 0);
        chk_val("swrst_im", out_im, 0);
        chk_bit("swrst_rdy", in_ready, 1'b1);
        for (int b = 0; b < 4; b++) beat(1'b1, 2, -3);
        in_val = 1'b0;
        chk_bit("swrst_oval", out_val, 1'b1);
        chk_val("swrst_grp_re", out_re, 8);
        chk_val("swrst_grp_im", out_im, -12);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Async rst while a sum is stalled in OUT
        for (int b = 0; b < 4; b++) beat(1'b1, 5, -5);
        in_val = 1'b0;
        tick();
        chk_bit("arst_pre_oval", out_val, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_bit("arst_oval", out_val, 1'b0);
        chk_val("arst_re", out_re, 0);
        chk_val("arst_im", out_im, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_bit("arst_rdy", in_ready, 1'b1);
        tick();

        // Gapped input: only the four valid beats count
        beat(1'b1, 1, 0);
        beat(1'b0, 1000, -777);
        beat(1'b0, -1234, 4321);
        beat(1'b1, 2, 0);
        beat(1'b0, 555, 666);
        beat(1'b1, 3, 0);
        chk_bit("gap_oval_early", out_val, 1'b0);
        beat(1'b1, 4, 0);
        in_val = 1'b0;
        chk_bit("gap_oval", out_val, 1'b1);
        chk_val("gap_re", out_re, 10);
        chk_val("gap_im", out_im, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_bit("gap_drain", out_val, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/complex_result_accumulator.md
Name: complex_result_accumulator

Overview:
- Downstream consumer of the complex multiplier's result stream (result_re/result_im via res_val/res_ready).
- Sums ACC_LEN consecutive complex products into one complex dot-product value.
- Emits the sum on a valid/ready output channel.
- Gives the complex multiplier datapath a complete complex MAC path.

Parameters:
- DATA_WIDTH, 8, operand width of the upstream multiplier; input parts are 2*DATA_WIDTH bits.
- ACC_LEN, 4, number of products summed per output; legal range 1..2**GUARD_BITS.
- GUARD_BITS, 4, extra accumulator MSBs; output width AW = 2*DATA_WIDTH+GUARD_BITS.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sw_rst  input  1  synchronous soft clear, active-high.
- in_val  input  1  upstream product valid (driven by multiplier res_val).
- in_ready  output  1  accumulator can accept a product (drives multiplier res_ready).
- in_re  input  2*DATA_WIDTH  real part of product, signed two's complement.
- in_im  input  2*DATA_WIDTH  imaginary part of product, signed two's complement.
- out_val  output  1  accumulated sum valid.
- out_ready  input  1  downstream accepts the sum.
- out_re  output  AW  accumulated real sum, signed.
- out_im  output  AW  accumulated imaginary sum, signed.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=ACC, beat counter=0, acc_re=acc_im=0.
  - out_val=0, out_re=out_im=0, in_ready=1 once rst is released.
- sw_rst=1 at a clock edge: same values as rst. Overrides any in/out handshake in that cycle; the product offered that cycle is not consumed.
- FSM has two states:
  - ACC: in_ready=1, out_val=0.
  - OUT: in_ready=0, out_val=1.
- Input beat:
  - Accepted when in_val && in_ready at a rising edge. Any other cycle leaves the counter and accumulators unchanged.
  - in_re/in_im are sign-extended to AW bits.
  - If counter==0: acc <= sext(in), i.e. load, never add to the previous group.
  - Otherwise: acc <= acc + sext(in), re and im independently.
  - Counter increments by 1. On the beat where counter==ACC_LEN-1: counter wraps to 0 and state goes to OUT.
- Output:
  - out_re/out_im are driven directly from acc_re/acc_im.
  - out_val rises the cycle after the last beat is accepted (latency 1 clock).
  - While out_val=1 && out_ready=0: out_val, out_re and out_im hold stable indefinitely; in_ready=0 back-pressures the multiplier.
  - On out_val && out_ready at an edge: state returns to ACC, in_ready=1 next cycle.
  - Accumulator values persist on out_re/out_im after the transfer until the next group's first beat loads them.
- Throughput: at most one sum per ACC_LEN+1 cycles. No overlap of OUT with input acceptance.
- Overflow: none possible while ACC_LEN <= 2**GUARD_BITS. No saturation or wrap logic required.
- ACC_LEN=1: every accepted beat loads acc and goes straight to OUT.
- Simultaneous events: rst dominates sw_rst, which dominates all handshakes. in_val is ignored in OUT.
- in_val may drop mid-group. Partial groups are held indefinitely until completed or cleared by rst/sw_rst.

Test Plan:
(Defaults DATA_WIDTH=8, ACC_LEN=4, GUARD_BITS=4, AW=20.)
1. Basic sum:
   - Stimulus: inputs (1,2),(3,-4),(5,6),(7,8) on 4 consecutive cycles, out_ready=1.
   - Response: out_val=1 exactly one cycle after the 4th accept, out_re=16, out_im=12; out_val low the next cycle, in_ready high.
2. Back-pressure then fresh group:
   - Stimulus: after test 1 values, out_ready held 0 for 5 cycles, then 1; next group is four (1,1).
   - Response: out_val/out_re=16/out_im=12 stable for all 5 cycles with in_ready=0; then out_re=4, out_im=4 (load, not 20/16).
3. Extremes:
   - Stimulus: 4 beats of in_re=16'h8000 (-32768), in_im=16'h7FFF (32767).
   - Response: out_re=-131072 (20'hE0000), out_im=131068 (20'h1FFFC), no wrap.
4. sw_rst mid-group:
   - Stimulus: accept (100,100),(100,100); pulse sw_rst together with in_val=1 carrying (9,9); then send four (2,-3).
   - Response: the (9,9) beat is not consumed; out_re=8, out_im=-12.
5. Async rst in OUT:
   - Stimulus: hold the group in OUT with out_ready=0, assert rst between clock edges.
   - Response: out_val=0 and out_re=out_im=0 immediately, without waiting for an edge; in_ready=1 after rst drops.
6. Gapped input:
   - Stimulus: in_val toggles 1,0,0,1,0,1,1 with payloads (1,0),(x),(x),(2,0),(x),(3,0),(4,0), where x are distinct junk values.
   - Response: only the 4 valid beats are counted; out_re=10, out_im=0.
